// File: rtl/core_stage_sequencer_if.sv
// Control/status bundle between the core top level and the five-stage sequencer.
// The master modport is the sequencer side; the slave modport is the core side.
interface core_stage_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             run;
  logic             step;
  logic             is_load;
  logic             is_store;
  logic             mem_ready;
  logic             if_en;
  logic             id_en;
  logic             ex_en;
  logic             mem_en;
  logic             wb_en;
  logic             mem_req;
  logic             pc_we;
  logic             halted;
  logic             mem_err;
  logic [CNT_W-1:0] retired;
  logic [2:0]       state;

  modport master (
    input  run, step, is_load, is_store, mem_ready,
    output if_en, id_en, ex_en, mem_en, wb_en, mem_req, pc_we,
    output halted, mem_err, retired, state
  );

  modport slave (
    output run, step, is_load, is_store, mem_ready,
    input  if_en, id_en, ex_en, mem_en, wb_en, mem_req, pc_we,
    input  halted, mem_err, retired, state
  );
endinterface

// File: rtl/core_stage_sequencer.sv
// One-hot stage sequencer (IF/ID/EX/MEM/WB) with run/halt/single-step control.
// Optional MEM wait timeout with sticky error: define SEQ_MEM_TIMEOUT_EN.
module core_stage_sequencer #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  core_stage_sequencer_if.master        bus
);

  typedef enum logic [2:0] {
    S_HALT = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5
  } state_t;

  state_t           cur;
  state_t           nxt;
  logic             access_q;
  logic [CNT_W-1:0] retired_q;
  logic             mem_err_q;
  logic             timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur       <= S_HALT;
      access_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      cur <= nxt;
      if (cur == S_ID) begin
        access_q <= bus.is_load | bus.is_store;
      end
      if (cur == S_WB) begin
        retired_q <= retired_q + 1'b1;
      end
    end
  end

  // run has priority over step in HALT; step outside HALT is simply not looked at
  always_comb begin
    nxt = S_HALT;
    case (cur)
      S_HALT: begin
        if (mem_err_q) begin
          nxt = S_HALT;
        end else if (bus.run || bus.step) begin
          nxt = S_IF;
        end else begin
          nxt = S_HALT;
        end
      end
      S_IF:  nxt = S_ID;
      S_ID:  nxt = S_EX;
      S_EX:  nxt = access_q ? S_MEM : S_WB;
      S_MEM: begin
        if (bus.mem_ready) begin
          nxt = S_WB;
        end else if (timeout) begin
          nxt = S_HALT;
        end else begin
          nxt = S_MEM;
        end
      end
      S_WB:    nxt = bus.run ? S_IF : S_HALT;
      default: nxt = S_HALT;
    endcase
  end

`ifdef SEQ_MEM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  logic [WAIT_W-1:0] wait_q;

  // Fires on the MEM cycle whose low mem_ready would bring the count to the limit
  assign timeout = !bus.mem_ready && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      if (cur == S_EX) begin
        wait_q <= '0;
      end else if (cur == S_MEM && !bus.mem_ready) begin
        wait_q <= wait_q + 1'b1;
      end
      if (cur == S_MEM && timeout) begin
        mem_err_q <= 1'b1;
      end
    end
  end
`else
  logic unused_cfg;

  assign timeout    = 1'b0;
  assign mem_err_q  = 1'b0;
  assign unused_cfg = (MEM_TIMEOUT != 0);
`endif

  assign bus.if_en   = (cur == S_IF);
  assign bus.id_en   = (cur == S_ID);
  assign bus.ex_en   = (cur == S_EX);
  assign bus.mem_en  = (cur == S_MEM);
  assign bus.wb_en   = (cur == S_WB);
  assign bus.mem_req = (cur == S_MEM);
  assign bus.pc_we   = (cur == S_WB);
  assign bus.halted  = (cur == S_HALT);
  assign bus.mem_err = mem_err_q;
  assign bus.retired = retired_q;
  assign bus.state   = cur;

endmodule

// File: tb/tb_core_stage_sequencer.sv
// Directed-vector bench for core_stage_sequencer; expected values are hand-derived.
// The MEM timeout section follows SEQ_MEM_TIMEOUT_EN like the design.
module tb_core_stage_sequencer;

  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cycles;
  int   memc;
  int   exp_ret;
  int   seq_st [4] = '{1, 2, 3, 5};

  core_stage_sequencer_if #(.CNT_W(CNT_W)) bus ();

  core_stage_sequencer #(
    .CNT_W      (CNT_W),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] outs();
    return {bus.if_en, bus.id_en, bus.ex_en, bus.mem_en, bus.wb_en, bus.mem_req, bus.pc_we};
  endfunction

  initial begin
    rst = 1'b1;
    bus.run = 1'b0; bus.step = 1'b0; bus.is_load = 1'b0;
    bus.is_store = 1'b0; bus.mem_ready = 1'b0;
    tick(); tick();
    chk("rst_state", bus.state, 0);
    chk("rst_outs", outs(), 0);
    chk("rst_halted", bus.halted, 1);
    chk("rst_retired", bus.retired, 0);
    chk("rst_mem_err", bus.mem_err, 0);

    // Free-running, three non-memory instructions
    rst = 1'b0;
    bus.run = 1'b1;
    tick();
    chk("run_first_if", bus.state, 1);
    chk("run_if_en", outs(), 7'b1000000);
    for (int i = 1; i < 12; i++) begin
      tick();
      chk("run_seq", bus.state, seq_st[i % 4]);
      if (i == 3) chk("run_wb_outs", outs(), 7'b0000101);
      if (i == 8) chk("run_retired_mid", bus.retired, 2);
    end
    bus.run = 1'b0;
    tick();
    chk("run_retired3", bus.retired, 3);
    chk("run_halt", bus.halted, 1);

    // Single step; a second pulse during EX is ignored
    bus.step = 1'b1;
    tick();
    chk("step_if", bus.state, 1);
    bus.step = 1'b0;
    tick(); tick();
    chk("step_ex", bus.state, 3);
    bus.step = 1'b1;
    tick();
    chk("step_wb", bus.state, 5);
    bus.step = 1'b0;
    tick();
    chk("step_halted", bus.halted, 1);
    chk("step_retired", bus.retired, 4);
    tick();
    chk("step_no_queue", bus.state, 0);

    // Store with mem_ready low for three MEM cycles
    bus.step = 1'b1;
    bus.is_store = 1'b1;
    tick();
    bus.step = 1'b0;
    cycles = 0;
    memc = 0;
    while (bus.state != 0 && cycles < 30) begin
      cycles++;
      if (bus.mem_req) memc++;
      if (cycles == 8) chk("store_wb_after_mem", bus.state, 5);
      bus.mem_ready = (bus.state == 4 && memc >= 4);
      tick();
    end
    bus.mem_ready = 1'b0;
    bus.is_store = 1'b0;
    chk("store_cycles", cycles, 8);
    chk("store_mem_req", memc, 4);
    chk("store_retired", bus.retired, 5);

    // Drop run during EX of a load
    bus.run = 1'b1;
    bus.is_load = 1'b1;
    tick(); tick(); tick();
    chk("drop_ex", bus.state, 3);
    bus.run = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    chk("drop_mem", bus.state, 4);
    tick();
    chk("drop_wb", bus.state, 5);
    tick();
    chk("drop_halt", bus.state, 0);
    chk("drop_retired", bus.retired, 6);
    bus.mem_ready = 1'b0;

    // Reset while in MEM
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    tick(); tick(); tick();
    chk("rstmem_in_mem", bus.state, 4);
    chk("rstmem_req", bus.mem_req, 1);
    rst = 1'b1;
    tick();
    chk("rstmem_state", bus.state, 0);
    chk("rstmem_outs", outs(), 0);
    chk("rstmem_halted", bus.halted, 1);
    chk("rstmem_retired", bus.retired, 0);
    rst = 1'b0;

`ifdef SEQ_MEM_TIMEOUT_EN
    // Timeout after four MEM cycles with mem_ready low
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    tick(); tick(); tick(); tick(); tick(); tick();
    chk("to_mem4", bus.state, 4);
    tick();
    chk("to_halt", bus.state, 0);
    chk("to_err", bus.mem_err, 1);
    chk("to_retired", bus.retired, 0);
    bus.run = 1'b1;
    bus.step = 1'b1;
    tick(); tick();
    chk("to_blocked", bus.state, 0);
    bus.run = 1'b0;
    bus.step = 1'b0;
    rst = 1'b1;
    tick();
    chk("to_err_clr", bus.mem_err, 0);
    rst = 1'b0;
    exp_ret = 0;
`else
    // Without the timeout MEM waits indefinitely
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    tick(); tick();
    for (int i = 0; i < 20; i++) tick();
    chk("wait_mem", bus.state, 4);
    chk("wait_no_err", bus.mem_err, 0);
    bus.mem_ready = 1'b1;
    tick();
    chk("wait_wb", bus.state, 5);
    bus.mem_ready = 1'b0;
    tick();
    chk("wait_halt", bus.state, 0);
    chk("wait_retired", bus.retired, 1);
    exp_ret = 1;
`endif
    bus.is_load = 1'b0;

    // run and step together: one instruction, no extra step recorded
    bus.run = 1'b1;
    bus.step = 1'b1;
    tick();
    chk("both_if", bus.state, 1);
    bus.run = 1'b0;
    bus.step = 1'b0;
    tick(); tick(); tick();
    chk("both_wb", bus.state, 5);
    tick();
    tick();
    chk("both_halt", bus.state, 0);
    chk("both_retired", bus.retired, exp_ret + 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
